// File: rtl/rect_fill_arbiter.sv
// rect_fill_arbiter
//   This block is a shared rectangle-fill engine for the single vga_adapter plot port.
//   Several requesters each ask for one solid XDIM x YDIM block. A round-robin arbiter
//   grants one requester at a time and latches that requester's origin and colour.
//   The engine then walks the block in row-major order, one pixel per cycle.
//
// Ports
//   Clock, Resetn       system clock; synchronous active-low reset
//   req                 per-requester fill request (level, held until done)
//   req_x/req_y         packed origins: requester i uses [8*i +: 8] / [7*i +: 7]
//   req_colour          packed colours: requester i uses [3*i +: 3]
//   grant               one-hot; high for the whole fill and the DONE cycle
//   done                one-cycle pulse to the requester whose fill just finished
//   busy                high in FILL and DONE
//   plot, vga_x, vga_y, vga_colour   vga_adapter write port
//
// Handshake: a requester raises req and holds it. It owns the engine while its grant
// bit is high. done[i] marks the last cycle of its fill. Dropping req early does not
// abort a fill that has started. A request that is still high is re-arbitrated only
// in the next IDLE cycle.
module rect_fill_arbiter #(
    parameter int NREQ    = 3,
    parameter int XDIM    = 10,
    parameter int YDIM    = 10,
    parameter int XSCREEN = 160,
    parameter int YSCREEN = 120
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_x,
    input  logic [7*NREQ-1:0]   req_y,
    input  logic [3*NREQ-1:0]   req_colour,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic                plot,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [2:0]          vga_colour
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      x0_q, x0_d;
    logic [6:0]      y0_q, y0_d;
    logic [2:0]      colour_q, colour_d;
    logic [7:0]      xc_q, xc_d;
    logic [6:0]      yc_q, yc_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [IW-1:0]   last_q, last_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;

    // Round-robin pick: the first set request scanning upward from last+1, with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        colour_d = colour_q;
        xc_d     = xc_q;
        yc_d     = yc_q;
        grant_d  = grant_q;
        gidx_d   = gidx_q;
        last_d   = last_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d = S_FILL;
                    gidx_d  = win_idx;
                    grant_d = '0;
                    xc_d    = '0;
                    yc_d    = '0;
                    for (int i = 0; i < NREQ; i++) begin
                        if (win_idx == IW'(i)) begin
                            x0_d       = req_x[8*i +: 8];
                            y0_d       = req_y[7*i +: 7];
                            colour_d   = req_colour[3*i +: 3];
                            grant_d[i] = 1'b1;
                        end
                    end
                end
            end
            S_FILL: begin
                // Row-major walk. It always runs to the end, even when pixels are clipped.
                if (xc_q == 8'(XDIM - 1)) begin
                    xc_d = '0;
                    if (yc_q == 7'(YDIM - 1)) begin
                        yc_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        yc_d = yc_q + 7'd1;
                    end
                end else begin
                    xc_d = xc_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                last_d  = gidx_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            colour_q <= '0;
            xc_q     <= '0;
            yc_q     <= '0;
            grant_q  <= '0;
            gidx_q   <= '0;
            last_q   <= IW'(NREQ - 1);
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            colour_q <= colour_d;
            xc_q     <= xc_d;
            yc_q     <= yc_d;
            grant_q  <= grant_d;
            gidx_q   <= gidx_d;
            last_q   <= last_d;
        end
    end

    // The sums are one bit wider than the coordinates so that an off-screen
    // pixel is seen as off-screen instead of wrapping back onto the screen.
    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       in_fill;

    always_comb begin
        x_sum      = {1'b0, x0_q} + {1'b0, xc_q};
        y_sum      = {1'b0, y0_q} + {1'b0, yc_q};
        in_fill    = (state_q == S_FILL);
        plot       = in_fill && (x_sum < 9'(XSCREEN)) && (y_sum < 8'(YSCREEN));
        vga_x      = in_fill ? x_sum[7:0] : '0;
        vga_y      = in_fill ? y_sum[6:0] : '0;
        vga_colour = in_fill ? colour_q : '0;
        busy       = (state_q != S_IDLE);
        grant      = grant_q;
        done       = (state_q == S_DONE) ? grant_q : '0;
    end

endmodule

// File: tb/tb_rect_fill_arbiter.sv
module tb_rect_fill_arbiter;

    logic        Clock;
    logic        Resetn;
    logic [2:0]  req;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic        plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    int total = 0;
    int bad   = 0;

    rect_fill_arbiter dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .plot       (plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour)
    );

    // clock / reset
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {plot, vga_x, vga_y, colour} for pixel i of a 10x10 fill at (x0, y0).
    task automatic pix_chk(input string tag, input int x0, input int y0, input int c, input int i);
        int xx;
        int yy;
        logic [18:0] e;
        xx = x0 + i % 10;
        yy = y0 + i / 10;
        e  = {((xx < 160) && (yy < 120)), 8'(xx), 7'(yy), 3'(c)};
        chk(tag, {13'd0, plot, vga_x, vga_y, vga_colour}, {13'd0, e});
    endtask

    initial begin
        int busy_cnt;
        int plot_cnt;
        int ng;
        int g_cyc[4];
        logic [2:0] g_val[4];
        logic [2:0] prev;

        Resetn = 1'b0; req = 3'b000; req_x = '0; req_y = '0; req_colour = '0;

        // T1: reset holds every output low even though all requests are high
        req = 3'b111;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("t1_grant", {29'd0, grant}, 32'd0);
            chk("t1_plot",  {31'd0, plot},  32'd0);
            chk("t1_busy",  {31'd0, busy},  32'd0);
            chk("t1_done",  {29'd0, done},  32'd0);
        end
        req = 3'b000; Resetn = 1'b1;
        tick();
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);

        // T2: single fill from requester 1 at (20,30), colour 010
        req_x[15:8] = 8'd20; req_y[13:7] = 7'd30; req_colour[5:3] = 3'b010;
        req = 3'b010;
        tick();
        chk("t2_grant", {29'd0, grant}, 32'b010);
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            pix_chk("t2_pixel", 20, 30, 2, i);
            if (busy) busy_cnt++;
            tick();
        end
        chk("t2_done",      {29'd0, done}, 32'b010);
        chk("t2_done_plot", {31'd0, plot}, 32'd0);
        if (busy) busy_cnt++;
        req = 3'b000;
        tick();
        chk("t2_busy_cnt",   busy_cnt, 32'd101);
        chk("t2_after_busy", {31'd0, busy}, 32'd0);
        chk("t2_after_done", {29'd0, done}, 32'd0);
        chk("t2_after_gnt",  {29'd0, grant}, 32'd0);

        // T3: round-robin between requesters 0 and 2 after a fresh reset
        Resetn = 1'b0;
        tick();
        req_x[7:0] = 8'd0; req_x[23:16] = 8'd40;
        Resetn = 1'b1; req = 3'b101;
        ng = 0; prev = 3'b000;
        for (int c = 1; c <= 450 && ng < 4; c++) begin
            tick();
            if (grant != 3'b000 && prev == 3'b000) begin
                g_cyc[ng] = c;
                g_val[ng] = grant;
                ng++;
            end
            prev = grant;
        end
        req = 3'b000;
        chk("t3_grant_count", ng, 32'd4);
        if (ng == 4) begin
            chk("t3_first_cyc", g_cyc[0], 32'd1);
            chk("t3_g0", {29'd0, g_val[0]}, 32'b001);
            chk("t3_g1", {29'd0, g_val[1]}, 32'b100);
            chk("t3_g2", {29'd0, g_val[2]}, 32'b001);
            chk("t3_g3", {29'd0, g_val[3]}, 32'b100);
            for (int k = 1; k < 4; k++) chk("t3_spacing", g_cyc[k] - g_cyc[k-1], 32'd102);
        end
        for (int c = 0; c < 200 && busy; c++) tick();
        chk("t3_drain_busy", {31'd0, busy}, 32'd0);
        tick();

        // T4: clipped fill at (155,115); only the on-screen 5x5 corner plots
        req_x[23:16] = 8'd155; req_y[20:14] = 7'd115; req_colour[8:6] = 3'b111;
        req = 3'b100;
        tick();
        chk("t4_grant", {29'd0, grant}, 32'b100);
        plot_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            pix_chk("t4_pixel", 155, 115, 7, i);
            if (plot) plot_cnt++;
            tick();
        end
        chk("t4_done",      {29'd0, done}, 32'b100);
        chk("t4_plot_cnt",  plot_cnt, 32'd25);
        req = 3'b000;
        tick();
        chk("t4_after_busy", {31'd0, busy}, 32'd0);

        // T5a: req and req_x change at pixel 40; the fill keeps its latched origin
        req_x[7:0] = 8'd5; req_y[6:0] = 7'd6; req_colour[2:0] = 3'b011;
        req = 3'b001;
        tick();
        chk("t5a_grant", {29'd0, grant}, 32'b001);
        for (int i = 0; i < 100; i++) begin
            pix_chk("t5a_pixel", 5, 6, 3, i);
            if (i == 40) begin
                req = 3'b000;
                req_x[7:0] = 8'd100;
            end
            tick();
        end
        chk("t5a_done", {29'd0, done}, 32'b001);
        tick();
        chk("t5a_after_busy", {31'd0, busy}, 32'd0);

        // T5b: reset at pixel 50 clears everything, and no done pulse follows
        req_x[7:0] = 8'd50;
        req = 3'b001;
        tick();
        chk("t5b_grant", {29'd0, grant}, 32'b001);
        for (int i = 0; i <= 50; i++) begin
            pix_chk("t5b_pixel", 50, 6, 3, i);
            if (i < 50) tick();
        end
        Resetn = 1'b0;
        req = 3'b000;
        tick();
        chk("t5b_rst_outs", {10'd0, grant, done, busy, plot, vga_x, vga_y, vga_colour}, 32'd0);
        Resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5b_no_done", {28'd0, busy, done}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
